// File: rtl/activity_monitor_pkg.sv
// Shared types and parameter defaults for the activity monitor.
package activity_monitor_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        READ = 2'd2
    } state_e;

endpackage

// File: rtl/activity_counter.sv
// Per-signal activity counters: saturating toggle count, optional saturating
// high-cycle count, and the previous-sample register for edge detection.
// Macro ACTIVITY_MONITOR_HIGH_TIME_EN builds the high-cycle counter; without it
// the high output is tied to zero and no counter register exists.
module activity_counter
    import activity_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             sig_bit,
    output logic [CNT_W-1:0] toggles,
    output logic [CNT_W-1:0] high
);

    logic prev;

    // Toggle counter and previous sample; clear re-arms prev with the live value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= 1'b0;
            toggles <= '0;
        end else if (clear) begin
            prev    <= sig_bit;
            toggles <= '0;
        end else if (enable) begin
            prev <= sig_bit;
            if ((sig_bit != prev) && (toggles != '1)) begin
                toggles <= toggles + 1'b1;
            end
        end
    end

`ifdef ACTIVITY_MONITOR_HIGH_TIME_EN
    logic [CNT_W-1:0] high_cnt;

    // High-cycle counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_cnt <= '0;
        end else if (clear) begin
            high_cnt <= '0;
        end else if (enable && sig_bit && (high_cnt != '1)) begin
            high_cnt <= high_cnt + 1'b1;
        end
    end

    assign high = high_cnt;
`else
    assign high = '0;
`endif

endmodule

// File: rtl/activity_monitor.sv
// Activity monitor top: measures toggles (and optionally high time) of each
// monitored signal over a start/stop window, then streams one record per
// signal through a valid/ready readout.
// Macro ACTIVITY_MONITOR_HIGH_TIME_EN enables the high-time counters.
module activity_monitor
    import activity_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [CNT_W-1:0] window,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_toggles,
    output logic [CNT_W-1:0] rd_high,
    output logic             rd_last
);

    state_e state, state_d;
    logic   clear;
    logic   enable;
    logic   handshake;

    logic [CNT_W-1:0] tog_cnt  [WIDTH];
    logic [CNT_W-1:0] high_cnt [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
        activity_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .enable  (enable),
            .sig_bit (sig[i]),
            .toggles (tog_cnt[i]),
            .high    (high_cnt[i])
        );
    end

    assign busy       = (state != IDLE);
    assign rd_last    = (state == READ) && (rd_idx == IDX_W'(WIDTH - 1));
    assign rd_toggles = tog_cnt[rd_idx];
    assign rd_high    = high_cnt[rd_idx];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and control decode; start wins over stop in IDLE.
    always_comb begin
        state_d   = state;
        clear     = 1'b0;
        enable    = 1'b0;
        rd_valid  = 1'b0;
        handshake = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                enable = 1'b1;
                if (stop) begin
                    state_d = READ;
                end
            end
            READ: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    handshake = 1'b1;
                    if (rd_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window length counter and readout index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window <= '0;
            rd_idx <= '0;
        end else begin
            if (clear) begin
                window <= '0;
            end else if (enable && (window != '1)) begin
                window <= window + 1'b1;
            end
            if (enable && stop) begin
                rd_idx <= '0;
            end else if (handshake) begin
                rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_activity_monitor.sv
// Bench for activity_monitor: two instances (CNT_W=16 and CNT_W=4) share the
// same stimulus; expectations come from a window-level model that counts
// toggles and ones over the applied sample sequence.
module tb_activity_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sig;
    logic        start;
    logic        stop;
    logic        rd_ready;

    logic        busy, rd_valid, rd_last;
    logic [15:0] window, rd_toggles, rd_high;
    logic [1:0]  rd_idx;

    logic        s_busy, s_rd_valid, s_rd_last;
    logic [3:0]  s_window, s_rd_toggles, s_rd_high;
    logic [1:0]  s_rd_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: expected unsaturated counts for the last window.
    int         exp_tog  [4];
    int         exp_high [4];
    int         exp_win;
    logic [3:0] stim_q[$];

    always #5 clk = ~clk;

    activity_monitor #(.WIDTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig        (sig),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .window     (window),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_idx     (rd_idx),
        .rd_toggles (rd_toggles),
        .rd_high    (rd_high),
        .rd_last    (rd_last)
    );

    activity_monitor #(.WIDTH(4), .CNT_W(4)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .sig        (sig),
        .start      (start),
        .stop       (stop),
        .busy       (s_busy),
        .window     (s_window),
        .rd_valid   (s_rd_valid),
        .rd_ready   (rd_ready),
        .rd_idx     (s_rd_idx),
        .rd_toggles (s_rd_toggles),
        .rd_high    (s_rd_high),
        .rd_last    (s_rd_last)
    );

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int hi_exp(input int v, input int w);
`ifdef ACTIVITY_MONITOR_HIGH_TIME_EN
        return sat(v, w);
`else
        return 0 * v * w;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compute expectations from stim_q, then drive start + the RUN samples.
    // With noise, start is waved during RUN and stop alongside the start pulse.
    task automatic run_window(input logic [3:0] pre, input bit noise);
        logic [3:0] p;
        p = pre;
        for (int i = 0; i < 4; i++) begin
            exp_tog[i]  = 0;
            exp_high[i] = 0;
        end
        exp_win = stim_q.size();
        foreach (stim_q[k]) begin
            for (int i = 0; i < 4; i++) begin
                if (stim_q[k][i] != p[i]) exp_tog[i]++;
                if (stim_q[k][i]) exp_high[i]++;
            end
            p = stim_q[k];
        end
        sig   = pre;
        start = 1'b1;
        stop  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        foreach (stim_q[k]) begin
            sig   = stim_q[k];
            stop  = (k == stim_q.size() - 1);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            n_checks++;
            if (busy !== 1'b1 || rd_valid !== 1'b0) begin
                $display("FAIL run_busy: busy=%b rd_valid=%b required 1/0", busy, rd_valid);
            end else n_pass++;
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Drain the four records; stall < 0 picks a random stall per record.
    task automatic read_out(input int stall, input bit noise);
        int n;
        for (int r = 0; r < 4; r++) begin
            n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int s = 0; s <= n; s++) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_idx !== 2'(r) || rd_last !== (r == 3)
                    || busy !== 1'b1) begin
                    $display("FAIL rec_ctrl[%0d]: valid=%b idx=%0d last=%b busy=%b required 1/%0d/%b/1",
                             r, rd_valid, rd_idx, rd_last, busy, r, (r == 3));
                end else n_pass++;
                n_checks++;
                if (rd_toggles !== 16'(sat(exp_tog[r], 16))
                    || rd_high !== 16'(hi_exp(exp_high[r], 16))
                    || window !== 16'(sat(exp_win, 16))) begin
                    $display("FAIL rec16[%0d]: tog=%0d high=%0d win=%0d required %0d/%0d/%0d",
                             r, rd_toggles, rd_high, window, sat(exp_tog[r], 16),
                             hi_exp(exp_high[r], 16), sat(exp_win, 16));
                end else n_pass++;
                n_checks++;
                if (s_rd_toggles !== 4'(sat(exp_tog[r], 4))
                    || s_rd_high !== 4'(hi_exp(exp_high[r], 4))
                    || s_window !== 4'(sat(exp_win, 4)) || s_rd_idx !== 2'(r)) begin
                    $display("FAIL rec4[%0d]: tog=%0d high=%0d win=%0d idx=%0d required %0d/%0d/%0d/%0d",
                             r, s_rd_toggles, s_rd_high, s_window, s_rd_idx,
                             sat(exp_tog[r], 4), hi_exp(exp_high[r], 4), sat(exp_win, 4), r);
                end else n_pass++;
                rd_ready = (s == n);
                start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                stop     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
        end
        rd_ready = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || s_busy !== 1'b0) begin
            $display("FAIL read_done: valid=%b busy=%b s_busy=%b required 0/0/0",
                     rd_valid, busy, s_busy);
        end else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; sig = '0; start = 0; stop = 0; rd_ready = 0;
        repeat (2) tick();
        n_checks++;
        if ({busy, rd_valid, rd_last} !== 3'b000 || rd_toggles !== '0 || rd_high !== '0
            || window !== '0 || s_window !== '0 || s_busy !== 1'b0) begin
            $display("FAIL reset: busy=%b valid=%b last=%b tog=%0d high=%0d win=%0d required all 0",
                     busy, rd_valid, rd_last, rd_toggles, rd_high, window);
        end else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || window !== '0) begin
            $display("FAIL reset_release: busy=%b win=%0d required 0/0", busy, window);
        end else n_pass++;
    endtask

    task automatic test_ramp();
        stim_q = {4'b0000, 4'b0001, 4'b0011, 4'b0111};
        repeat (11) stim_q.push_back(4'b1111);
        run_window(4'b0000, 1'b0);
        n_checks++;
        if (window !== 16'd15 || rd_toggles !== 16'd1) begin
            $display("FAIL ramp_fixed: win=%0d tog0=%0d required 15/1", window, rd_toggles);
        end else n_pass++;
`ifdef ACTIVITY_MONITOR_HIGH_TIME_EN
        n_checks++;
        if (rd_high !== 16'd14) begin
            $display("FAIL ramp_high0: high0=%0d required 14", rd_high);
        end else n_pass++;
`endif
        read_out(0, 1'b0);
    endtask

    task automatic test_stable();
        stim_q = {};
        repeat (5) stim_q.push_back(4'b1010);
        run_window(4'b1010, 1'b0);
        n_checks++;
        if (window !== 16'd5 || rd_toggles !== 16'd0) begin
            $display("FAIL stable_fixed: win=%0d tog0=%0d required 5/0", window, rd_toggles);
        end else n_pass++;
        read_out(1, 1'b0);
    endtask

    task automatic test_saturate();
        stim_q = {};
        for (int k = 0; k < 20; k++) stim_q.push_back((k % 2 == 0) ? 4'b0001 : 4'b0000);
        run_window(4'b0000, 1'b0);
        n_checks++;
        if (s_rd_toggles !== 4'd15 || s_window !== 4'd15 || rd_toggles !== 16'd20) begin
            $display("FAIL saturate: s_tog=%0d s_win=%0d tog=%0d required 15/15/20",
                     s_rd_toggles, s_window, rd_toggles);
        end else n_pass++;
        read_out(0, 1'b0);
    endtask

    task automatic test_stall();
        stim_q = {};
        for (int k = 0; k < 9; k++) stim_q.push_back(4'($urandom));
        run_window(4'($urandom), 1'b0);
        read_out(3, 1'b0);
    endtask

    task automatic test_idle_hold();
        for (int k = 0; k < 6; k++) begin
            sig  = 4'($urandom);
            stop = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (busy !== 1'b0 || window !== 16'(sat(exp_win, 16))
                || rd_toggles !== 16'(sat(exp_tog[0], 16))) begin
                $display("FAIL idle_hold: busy=%b win=%0d tog0=%0d required 0/%0d/%0d",
                         busy, window, rd_toggles, sat(exp_win, 16), sat(exp_tog[0], 16));
            end else n_pass++;
        end
        stop = 1'b0;
    endtask

    task automatic test_random();
        int len;
        for (int w = 0; w < 8; w++) begin
            len    = $urandom_range(1, 40);
            stim_q = {};
            for (int k = 0; k < len; k++) stim_q.push_back(4'($urandom));
            run_window(4'($urandom), 1'b1);
            read_out(-1, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        stim_q = {};
        repeat (4) stim_q.push_back(4'b0101);
        sig = 4'b0000; start = 1'b1;
        tick();
        start = 1'b0; sig = 4'b0101;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || window !== '0 || rd_valid !== 1'b0) begin
            $display("FAIL rst_mid_run: busy=%b win=%0d valid=%b required 0/0/0",
                     busy, window, rd_valid);
        end else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        run_window(4'b1111, 1'b0);
        rd_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_toggles !== '0 || window !== '0
            || rd_last !== 1'b0) begin
            $display("FAIL rst_mid_read: busy=%b valid=%b tog=%0d win=%0d last=%b required 0",
                     busy, rd_valid, rd_toggles, window, rd_last);
        end else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        stim_q = {};
        for (int k = 0; k < 7; k++) stim_q.push_back(4'($urandom));
        run_window(4'($urandom), 1'b0);
        read_out(-1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stable();
        test_saturate();
        test_stall();
        test_idle_hold();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
